wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 83 ++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file.
// The file holds 32 x 32-bit registers. Register 0 always reads zero.
// It has two combinational read ports and a retired-instruction counter.
// Optional feature: define WB_BYPASS_EN to forward the write-back value to a
// read port in the same cycle as the write. Without it, the reads return the
// array contents only.
module wb_regfile #(
  parameter int RETIRE_W = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Valid,
  input  logic                RegWrite,
  input  logic                MemtoReg,
  input  logic [31:0]         ReadData,
  input  logic [31:0]         AluResult,
  input  logic [4:0]          Mux,
  input  logic [4:0]          RdAddrA,
  input  logic [4:0]          RdAddrB,
  output logic [31:0]         RdDataA,
  output logic [31:0]         RdDataB,
  output logic [31:0]         WbData,
  output logic [RETIRE_W-1:0] RetireCount
);

  logic [31:0]         regs_q [0:31];
  logic [RETIRE_W-1:0] retire_q;
  logic [RETIRE_W-1:0] retire_d;
  logic                wr_en;
  logic [4:0]          rd_addr [0:1];
  logic [31:0]         rd_data [0:1];

  // Select the write-back value, and qualify the write (reset drops the instruction).
  always_comb begin
    WbData   = MemtoReg ? ReadData : AluResult;
    wr_en    = Valid && RegWrite && (Mux != 5'd0) && !Rst;
    retire_d = retire_q + RETIRE_W'(1);
  end

  // Update the register array and the retire counter; reset has priority over both.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      retire_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[Mux] <= WbData;
      end
      if (Valid) begin
        retire_q <= retire_d;
      end
    end
  end

  assign rd_addr[0] = RdAddrA;
  assign rd_addr[1] = RdAddrB;

  // The two read ports are identical, so generate one read path per port.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      // Combinational read. Index 0 is forced to zero.
      // When enabled, a qualified write to the same index is forwarded.
      always_comb begin
        rd_data[gi] = regs_q[rd_addr[gi]];
`ifdef WB_BYPASS_EN
        if (wr_en && (rd_addr[gi] == Mux)) begin
          rd_data[gi] = WbData;
        end
`endif
        if (rd_addr[gi] == 5'd0) begin
          rd_data[gi] = 32'd0;
        end
      end
    end
  endgenerate

  assign RdDataA     = rd_data[0];
  assign RdDataB     = rd_data[1];
  assign RetireCount = retire_q;

endmodule
